// File: rtl/fetch_stage.sv
// RISC-V instruction fetch stage: owns the PC, addresses IMEM combinationally and
// registers the returned word into the IF/ID pipeline register for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic             fetch_halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } ifid_t;

    localparam ifid_t            BUBBLE  = '{valid: 1'b0, instr: NOP_INSTR,
                                             pc: '0, pc_plus4: '0};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    ifid_t            ifid_q;
    ifid_t            ifid_d;
    logic             misalign_q;
    logic             misalign_d;
    logic             halted_q;
    logic             halted_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [XLEN-1:0]  pc_plus4;
    logic             redirect_misaligned;

    assign pc_plus4            = pc_q + XLEN'(4);
    assign redirect_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one boot cycle, then run until a misaligned redirect
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect_misaligned) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // Datapath next values: PC selection and IF/ID capture priority
    always_comb begin
        pc_d       = pc_q;
        ifid_d     = ifid_q;
        misalign_d = misalign_q;
        halted_d   = (state_d == HALT);
        cnt_d      = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect_misaligned) begin
                    misalign_d = 1'b1;
                    ifid_d     = BUBBLE;
                end else begin
                    // A resolved redirect beats a hazard stall on the PC
                    if (redirect_valid) begin
                        pc_d = redirect_target;
                    end else if (!stall_f) begin
                        pc_d = pc_plus4;
                    end

                    if (flush_d || redirect_valid) begin
                        ifid_d = BUBBLE;
                    end else if (stall_d) begin
                        ifid_d = ifid_q;
                    end else if (stall_f) begin
                        // PC is held, so capturing now would duplicate it next cycle
                        ifid_d = BUBBLE;
                    end else begin
                        ifid_d.valid    = 1'b1;
                        ifid_d.instr    = imem_rdata;
                        ifid_d.pc       = pc_q;
                        ifid_d.pc_plus4 = pc_plus4;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            HALT: begin
                ifid_d = BUBBLE;
            end
            default: begin
                ifid_d = ifid_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ifid_q     <= BUBBLE;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_valid    = ifid_q.valid;
    assign if_id_instr    = ifid_q.instr;
    assign if_id_pc       = ifid_q.pc;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign fetch_halted   = halted_q;
    assign misalign_err   = misalign_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control inputs,
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int unsigned CNT_MAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, stall_f, stall_d, flush_d, redirect_valid;
    logic [31:0] redirect_target, imem_addr, imem_rdata;
    logic        if_id_valid, fetch_halted, misalign_err;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
    logic [15:0] fetch_count;

    // saturation instance (4-bit counter)
    logic        rst_s;
    logic [31:0] addr_s, rdata_s, instr_s, ipc_s, ip4_s;
    logic        valid_s, halted_s, mis_s;
    logic [3:0]  count_s;

    // wrap instance (reset PC near the top of the address space)
    logic        rst_w;
    logic [31:0] addr_w, rdata_w, instr_w, ipc_w, ip4_w;
    logic        valid_w, halted_w, mis_w;
    logic [15:0] count_w;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00a0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata_s    = mem_word(addr_s);
    assign rdata_w    = mem_word(addr_w);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .fetch_halted(fetch_halted),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    fetch_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst_s), .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .imem_addr(addr_s), .imem_rdata(rdata_s),
        .if_id_valid(valid_s), .if_id_instr(instr_s), .if_id_pc(ipc_s),
        .if_id_pc_plus4(ip4_s), .fetch_halted(halted_s),
        .misalign_err(mis_s), .fetch_count(count_s)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst_w), .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .imem_addr(addr_w), .imem_rdata(rdata_w),
        .if_id_valid(valid_w), .if_id_instr(instr_w), .if_id_pc(ipc_w),
        .if_id_pc_plus4(ip4_w), .fetch_halted(halted_w),
        .misalign_err(mis_w), .fetch_count(count_w)
    );

    // Behavioural model of the main instance
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
    logic        m_boot, m_halt, m_mis, m_valid;
    int unsigned m_cnt;

    task automatic model_bubble();
        m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_ip4 = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] cur;
        cur = m_pc;
        if (rst) begin
            m_pc = RST_PC; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 0;
            model_bubble();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            model_bubble();
        end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
            m_halt = 1'b1; m_mis = 1'b1;
            model_bubble();
        end else begin
            if (redirect_valid)  m_pc = redirect_target;
            else if (!stall_f)   m_pc = cur + 32'd4;
            if (flush_d || redirect_valid) model_bubble();
            else if (stall_d) begin
                // IF/ID unchanged
            end else if (stall_f) model_bubble();
            else begin
                m_valid = 1'b1; m_instr = mem_word(cur); m_ipc = cur; m_ip4 = cur + 32'd4;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("imem_addr", imem_addr, m_pc);
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc", if_id_pc, m_ipc);
        check("if_id_pc_plus4", if_id_pc_plus4, m_ip4);
        check("fetch_halted", 32'(fetch_halted), 32'(m_halt));
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
    endtask

    initial begin
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_ip4 = 32'h0;
        m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_valid = 1'b0; m_cnt = 0;
        idle_inputs();
        rst = 1'b1; rst_s = 1'b1; rst_w = 1'b1;
        #1;

        // reset held two cycles, then boot cycle, then first captures
        cycle();
        cycle();
        check("reset_valid", 32'(if_id_valid), 32'h0);
        check("reset_instr", if_id_instr, NOP);
        rst = 1'b0; rst_s = 1'b0;
        cycle();
        check("boot_pc_held", imem_addr, 32'h0);
        check("boot_no_capture", 32'(if_id_valid), 32'h0);
        cycle();
        check("cap0_pc", if_id_pc, 32'h0);
        check("cap0_instr", if_id_instr, 32'h0050_0093);
        cycle();
        check("cap4_pc", if_id_pc, 32'h4);
        check("cap4_instr", if_id_instr, 32'h00a0_0113);
        check("cap4_count", 32'(fetch_count), 32'd2);

        // free run to 0x14 then redirect to 0x1C
        cycle(); cycle(); cycle();
        check("run_pc_14", imem_addr, 32'h14);
        redirect_valid = 1'b1; redirect_target = 32'h1C;
        cycle();
        check("redir_addr", imem_addr, 32'h1C);
        check("redir_bubble", 32'(if_id_valid), 32'h0);
        idle_inputs();
        cycle();
        check("redir_capture", if_id_pc, 32'h1C);

        // park PC at 0x8 with 0x4 in IF/ID, then stall both stages
        redirect_valid = 1'b1; redirect_target = 32'h4;
        cycle();
        idle_inputs();
        cycle();
        stall_f = 1'b1; stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_pc", imem_addr, 32'h8);
            check("stall_hold_pc", if_id_pc, 32'h4);
            check("stall_count", 32'(fetch_count), 32'd7);
        end
        idle_inputs();
        cycle();
        check("release_cap8", if_id_pc, 32'h8);
        cycle();
        check("release_capC", if_id_pc, 32'hC);
        check("release_count", 32'(fetch_count), 32'd9);

        // flush beats stall_d; redirect beats stall_f
        stall_d = 1'b1; flush_d = 1'b1;
        cycle();
        check("flush_over_stall", 32'(if_id_valid), 32'h0);
        idle_inputs();
        stall_f = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        cycle();
        check("redir_over_stall", imem_addr, 32'h40);

        // misaligned redirect halts until reset
        idle_inputs();
        redirect_valid = 1'b1; redirect_target = 32'h22;
        cycle();
        check("halt_mis", 32'(misalign_err), 32'h1);
        check("halt_flag", 32'(fetch_halted), 32'h1);
        for (int i = 0; i < 4; i++) begin
            stall_f = 1'($urandom); stall_d = 1'($urandom); flush_d = 1'($urandom);
            redirect_valid = 1'b1; redirect_target = $urandom & 32'hFFFF_FFFC;
            cycle();
            check("halt_pc_frozen", imem_addr, 32'h40);
            check("halt_bubble", 32'(if_id_valid), 32'h0);
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        check("restart_pc", imem_addr, RST_PC);
        check("restart_halt", 32'(fetch_halted), 32'h0);
        check("restart_mis", 32'(misalign_err), 32'h0);
        rst = 1'b0;

        // PC wrap on the high-reset-PC instance
        rst_w = 1'b0;
        cycle();
        check("wrap_boot", addr_w, 32'hFFFF_FFF8);
        cycle();
        check("wrap_pc0", ipc_w, 32'hFFFF_FFF8);
        check("wrap_p40", ip4_w, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc1", ipc_w, 32'hFFFF_FFFC);
        check("wrap_p41", ip4_w, 32'h0);
        cycle();
        check("wrap_pc2", ipc_w, 32'h0);

        // randomized control traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, m_halt ? 6 : 80) == 0);
            stall_f        = ($urandom_range(0, 3) == 0);
            stall_d        = ($urandom_range(0, 3) == 0);
            flush_d        = ($urandom_range(0, 5) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0)
                redirect_target = 32'hFFFF_FFF0;
            else
                redirect_target = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0)
                redirect_target[1:0] = 2'($urandom_range(1, 3));
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        // 4-bit counter instance has free-run fetched far more than 15 times
        check("sat_count", 32'(count_s), 32'd15);
        check("sat_valid", 32'(valid_s), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
